pipeline_hazard_controller: RTL and testbench
=============================================

Name: pipeline_hazard_controller

Overview:
- Central sequencing unit for the 5-stage pipelined ARMv8 core (IF/ID/EX/MEM/WB).
- Generates PC-write, pipeline-register write-enable, flush and PC-source controls.
- Covers three cases: load-use stalls, taken-branch redirects (B, BL, CBZ/CBNZ resolved in MEM), and freezes for a multi-cycle data memory.
- Also provides a memory watchdog and saturating stall/flush performance counters.

Parameters:
- REG_ADDR_W, 5, register specifier width.
- CNT_W, 32, performance counter width.
- MEM_TIMEOUT, 64, max cycles a MEM access may wait for mem_ready before error.

Ports:
- clock  input  1  core clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- id_valid  input  1  IF/ID holds a real instruction.
- id_rn  input  REG_ADDR_W  Rn field of instruction in ID.
- id_rm  input  REG_ADDR_W  Rm/Rt field of instruction in ID.
- id_uses_rm  input  1  ID instruction reads id_rm (R-type, STUR, CBZ).
- ex_mem_read  input  1  instruction in EX is a load (LDUR).
- ex_rd  input  REG_ADDR_W  destination of instruction in EX.
- mem_branch_taken  input  1  branch in MEM resolved taken.
- mem_req  input  1  instruction in MEM accesses data memory.
- mem_ready  input  1  data memory completes access this cycle.
- pc_write  output  1  PC register load enable.
- pc_src  output  1  1 = PC loads branch target, 0 = PC+4.
- ifid_write  output  1  IF/ID load enable.
- ifid_flush  output  1  IF/ID cleared to bubble on next edge.
- idex_flush  output  1  ID/EX cleared to bubble.
- exmem_flush  output  1  EX/MEM cleared to bubble.
- freeze  output  1  ID/EX, EX/MEM and MEM/WB hold their contents.
- mem_error  output  1  sticky watchdog error.
- stall_cycles  output  CNT_W  cycles with pc_write=0 after BOOT.
- flush_events  output  CNT_W  count of taken-branch redirects.

Behaviour:
- States:
  - BOOT: entered during reset; lasts one cycle after reset release.
  - RUN: normal operation.
  - MEM_WAIT: waiting on the data memory.
  - ERROR: watchdog expired.
- Outputs are Mealy: combinational from state and the current-cycle inputs. State, watchdog counter and perf counters are registered.
- While reset=0:
  - State is BOOT.
  - pc_write=0, ifid_write=0, pc_src=0, freeze=0.
  - All three flush outputs =1.
  - mem_error=0; both counters=0; watchdog=0.
- BOOT:
  - Outputs are the same as in reset.
  - Goes to RUN unconditionally on the next edge.
- RUN priority, evaluated in this order:
  1. mem_req && !mem_ready:
     - freeze=1, pc_write=0, ifid_write=0, no flushes.
     - Watchdog loads 1; go to MEM_WAIT.
  2. mem_branch_taken:
     - pc_write=1, pc_src=1, ifid_flush=1, idex_flush=1, exmem_flush=1.
     - The branch itself proceeds to WB, so the BL write to X30 is preserved.
     - flush_events increments.
  3. Load-use:
     - Condition: id_valid && ex_mem_read && ex_rd!=XZR && (ex_rd==id_rn || (id_uses_rm && ex_rd==id_rm)).
     - Response: pc_write=0, ifid_write=0, idex_flush=1.
  4. Otherwise: pc_write=1, ifid_write=1, all other controls 0.
- mem_branch_taken and mem_req are never both 1; if they are, the memory case wins.
- MEM_WAIT:
  - Freeze outputs as in RUN case 1 each cycle; watchdog increments.
  - mem_ready=1: outputs are evaluated as RUN cases 2–4 this cycle (the load-use check uses current inputs), then the state returns to RUN.
  - Watchdog reaches MEM_TIMEOUT with mem_ready=0: mem_error is set and the state goes to ERROR.
- ERROR:
  - freeze=1, pc_write=0, ifid_write=0.
  - Left only by reset.
- stall_cycles increments every cycle with pc_write=0 in RUN, MEM_WAIT or ERROR.
- Both counters saturate at all-ones; no wrap.
- Reset asserted mid-stall or mid-wait: immediate return to the reset values above; any pending access is abandoned.

Decomposition:
- Package arm_pipe_pkg holds:
  - the state enum (BOOT, RUN, MEM_WAIT, ERROR);
  - constant XZR = 31;
  - REG_ADDR_W default.
- Sub-module sat_counter (parameter CNT_W; inputs clock, reset, inc; output count) is instantiated twice, for stall_cycles and flush_events.

Test Plan:
- Reset release: hold reset=0 for 15 ns, then release -> one BOOT cycle with all flushes=1 and pc_write=0; next cycle pc_write=1, ifid_write=1, counters=0.
- Load-use: ex_mem_read=1, ex_rd=9, id_rn=9 -> one cycle of pc_write=0, ifid_write=0, idex_flush=1; stall_cycles=1. Repeat with ex_rd=31 -> no stall.
- Taken branch (B #24, then BL #8): mem_branch_taken=1 -> pc_src=1 and all three flushes for exactly one cycle each time; flush_events=2; the MEM/WB path is not frozen.
- Memory wait: mem_req=1, mem_ready low for 3 cycles -> freeze=1 for 3 cycles, return to RUN on the ready cycle; stall_cycles +3.
- Watchdog: MEM_TIMEOUT=4, mem_ready held 0 -> mem_error=1 on the 4th wait cycle; stays frozen until reset; reset clears mem_error.
- Saturation: CNT_W=3, 9 taken branches -> flush_events=7.

Source files
------------

// File: rtl/arm_pipe_pkg.sv
// +------------------------------------------------------------------+
// | arm_pipe_pkg: shared types and constants for the ARMv8 pipeline   |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

package arm_pipe_pkg;

  localparam int REG_ADDR_W_DEFAULT = 5;
  localparam int XZR                = 31;

  typedef enum logic [1:0] {
    BOOT     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2,
    ERROR    = 2'd3
  } pipe_state_e;

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// +------------------------------------------------------------------+
// | sat_counter: up-counter that sticks at all-ones instead of wrapping |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

`default_nettype wire

// File: rtl/pipeline_hazard_controller.sv
// +------------------------------------------------------------------+
// | pipeline_hazard_controller: stall/flush/freeze sequencing for the  |
// | 5-stage ARMv8 pipeline, with memory watchdog and perf counters.   |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

module pipeline_hazard_controller
  import arm_pipe_pkg::*;
#(
  parameter int REG_ADDR_W  = REG_ADDR_W_DEFAULT,
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rn,
  input  logic [REG_ADDR_W-1:0] id_rm,
  input  logic                  id_uses_rm,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  mem_branch_taken,
  input  logic                  mem_req,
  input  logic                  mem_ready,
  output logic                  pc_write,
  output logic                  pc_src,
  output logic                  ifid_write,
  output logic                  ifid_flush,
  output logic                  idex_flush,
  output logic                  exmem_flush,
  output logic                  freeze,
  output logic                  mem_error,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [CNT_W-1:0]      flush_events
);

  localparam int WD_W = $clog2(MEM_TIMEOUT + 1);

  pipe_state_e     state_q, state_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic            err_q, err_d;
  logic            load_use;
  logic            run_eval;
  logic            flush_inc;
  logic            stall_inc;

  // Loads into XZR are discarded, so they can never create a dependence.
  assign load_use = id_valid && ex_mem_read && (ex_rd != REG_ADDR_W'(XZR)) &&
                    ((ex_rd == id_rn) || (id_uses_rm && (ex_rd == id_rm)));

  always_comb begin
    state_d     = state_q;
    wd_d        = wd_q;
    err_d       = err_q;
    run_eval    = 1'b0;
    flush_inc   = 1'b0;
    pc_write    = 1'b0;
    pc_src      = 1'b0;
    ifid_write  = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    freeze      = 1'b0;

    case (state_q)
      BOOT: begin
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
        state_d     = RUN;
      end
      RUN: begin
        if (mem_req && !mem_ready) begin
          freeze  = 1'b1;
          wd_d    = WD_W'(1);
          state_d = MEM_WAIT;
        end else begin
          run_eval = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (mem_ready) begin
          run_eval = 1'b1;
          wd_d     = '0;
          state_d  = RUN;
        end else begin
          freeze = 1'b1;
          wd_d   = wd_q + WD_W'(1);
          if (wd_q >= WD_W'(MEM_TIMEOUT - 1)) begin
            err_d   = 1'b1;
            state_d = ERROR;
          end
        end
      end
      ERROR: begin
        freeze = 1'b1;
      end
      default: begin
        state_d = BOOT;
      end
    endcase

    // The branch in MEM is not flushed, so a BL still writes X30 in WB.
    if (run_eval) begin
      if (mem_branch_taken) begin
        pc_write    = 1'b1;
        pc_src      = 1'b1;
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
        flush_inc   = 1'b1;
      end else if (load_use) begin
        idex_flush = 1'b1;
      end else begin
        pc_write   = 1'b1;
        ifid_write = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= BOOT;
      wd_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
      err_q   <= err_d;
    end
  end

  // Error flag shows up in the very cycle the watchdog expires.
  assign mem_error = err_d;
  assign stall_inc = (state_q != BOOT) && !pc_write;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (stall_inc),
    .count (stall_cycles)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (flush_inc),
    .count (flush_events)
  );

endmodule

`default_nettype wire

// File: tb/tb_pipeline_hazard_controller.sv
// +------------------------------------------------------------------+
// | tb_pipeline_hazard_controller: directed self-checking bench        |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

module tb_pipeline_hazard_controller;

  localparam int RW = 5;
  localparam int CW = 3;
  localparam int TO = 4;

  // Control vector order: pc_write, pc_src, ifid_write, ifid_flush,
  // idex_flush, exmem_flush, freeze, mem_error
  localparam logic [7:0] C_BOOT = 8'b0001_1100;
  localparam logic [7:0] C_NORM = 8'b1010_0000;
  localparam logic [7:0] C_LU   = 8'b0000_1000;
  localparam logic [7:0] C_BR   = 8'b1101_1100;
  localparam logic [7:0] C_FRZ  = 8'b0000_0010;
  localparam logic [7:0] C_ERR  = 8'b0000_0011;

  logic          clock;
  logic          reset;
  logic          id_valid;
  logic [RW-1:0] id_rn;
  logic [RW-1:0] id_rm;
  logic          id_uses_rm;
  logic          ex_mem_read;
  logic [RW-1:0] ex_rd;
  logic          mem_branch_taken;
  logic          mem_req;
  logic          mem_ready;
  logic          pc_write, pc_src, ifid_write, ifid_flush;
  logic          idex_flush, exmem_flush, freeze, mem_error;
  logic [CW-1:0] stall_cycles;
  logic [CW-1:0] flush_events;
  logic [7:0]    ctl;

  int errors = 0;
  int checks = 0;

  pipeline_hazard_controller #(
    .REG_ADDR_W  (RW),
    .CNT_W       (CW),
    .MEM_TIMEOUT (TO)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .id_valid         (id_valid),
    .id_rn            (id_rn),
    .id_rm            (id_rm),
    .id_uses_rm       (id_uses_rm),
    .ex_mem_read      (ex_mem_read),
    .ex_rd            (ex_rd),
    .mem_branch_taken (mem_branch_taken),
    .mem_req          (mem_req),
    .mem_ready        (mem_ready),
    .pc_write         (pc_write),
    .pc_src           (pc_src),
    .ifid_write       (ifid_write),
    .ifid_flush       (ifid_flush),
    .idex_flush       (idex_flush),
    .exmem_flush      (exmem_flush),
    .freeze           (freeze),
    .mem_error        (mem_error),
    .stall_cycles     (stall_cycles),
    .flush_events     (flush_events)
  );

  assign ctl = {pc_write, pc_src, ifid_write, ifid_flush,
                idex_flush, exmem_flush, freeze, mem_error};

  // Posedges at 10, 20, 30 ...; negedges at 5, 15, 25 ...
  initial begin
    clock = 1'b1;
    forever #5 clock = ~clock;
  end

  task automatic set_in(input logic v, input logic mr, input logic urm,
                        input logic [RW-1:0] rd, input logic [RW-1:0] rn,
                        input logic [RW-1:0] rm, input logic br,
                        input logic mq, input logic my);
    id_valid = v; ex_mem_read = mr; id_uses_rm = urm;
    ex_rd = rd; id_rn = rn; id_rm = rm;
    mem_branch_taken = br; mem_req = mq; mem_ready = my;
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  // Leaves the DUT in RUN at posedge+1 with counters cleared.
  task automatic restart();
    reset = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clock);
    reset = 1'b1;
    next_cycle();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #12;
    checks++;
    if (ctl !== C_BOOT) begin
      errors++; $display("FAIL reset_ctl: got %b want %b", ctl, C_BOOT);
    end
    checks++;
    if (stall_cycles !== 3'd0 || flush_events !== 3'd0) begin
      errors++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", stall_cycles, flush_events);
    end
    #3 reset = 1'b1;
    #1;
    checks++;
    if (ctl !== C_BOOT) begin
      errors++; $display("FAIL boot_ctl: got %b want %b", ctl, C_BOOT);
    end
    next_cycle();
    checks++;
    if (ctl !== C_NORM) begin
      errors++; $display("FAIL first_run_ctl: got %b want %b", ctl, C_NORM);
    end
    checks++;
    if (stall_cycles !== 3'd0 || flush_events !== 3'd0) begin
      errors++; $display("FAIL first_run_cnt: got %0d/%0d want 0/0", stall_cycles, flush_events);
    end
  endtask

  task automatic test_load_use();
    logic [7:0] exp [6];
    restart();
    exp = '{C_LU, C_NORM, C_NORM, C_LU, C_NORM, C_NORM};
    for (int i = 0; i < 6; i++) begin
      case (i)
        0: set_in(1, 1, 0, 5'd9,  5'd9,  5'd0, 0, 0, 0);
        1: set_in(1, 0, 0, 5'd9,  5'd9,  5'd0, 0, 0, 0);
        2: set_in(1, 1, 0, 5'd31, 5'd31, 5'd0, 0, 0, 0);
        3: set_in(1, 1, 1, 5'd9,  5'd3,  5'd9, 0, 0, 0);
        4: set_in(1, 1, 0, 5'd9,  5'd3,  5'd9, 0, 0, 0);
        default: set_in(0, 1, 0, 5'd9, 5'd9, 5'd9, 0, 0, 0);
      endcase
      @(negedge clock);
      checks++;
      if (ctl !== exp[i]) begin
        errors++; $display("FAIL load_use[%0d]: got %b want %b", i, ctl, exp[i]);
      end
      next_cycle();
      if (i == 0) begin
        checks++;
        if (stall_cycles !== 3'd1) begin
          errors++; $display("FAIL load_use_stall1: got %0d want 1", stall_cycles);
        end
      end
    end
    checks++;
    if (stall_cycles !== 3'd2) begin
      errors++; $display("FAIL load_use_stall2: got %0d want 2", stall_cycles);
    end
  endtask

  task automatic test_branch();
    restart();
    for (int n = 0; n < 2; n++) begin
      // Branch also outranks a coincident load-use hazard.
      set_in(1, 1, 0, 5'd5, 5'd5, 5'd0, 1, 0, 0);
      @(negedge clock);
      checks++;
      if (ctl !== C_BR) begin
        errors++; $display("FAIL branch_ctl[%0d]: got %b want %b", n, ctl, C_BR);
      end
      next_cycle();
      set_in(1, 0, 0, 5'd0, 5'd1, 5'd2, 0, 0, 0);
      @(negedge clock);
      checks++;
      if (ctl !== C_NORM) begin
        errors++; $display("FAIL branch_after[%0d]: got %b want %b", n, ctl, C_NORM);
      end
      next_cycle();
    end
    checks++;
    if (flush_events !== 3'd2 || stall_cycles !== 3'd0) begin
      errors++; $display("FAIL branch_cnt: got %0d/%0d want 2/0", flush_events, stall_cycles);
    end
  endtask

  task automatic test_mem_wait();
    logic [7:0] exp [9];
    restart();
    exp = '{C_FRZ, C_FRZ, C_FRZ, C_NORM, C_NORM, C_FRZ, C_LU, C_NORM, C_NORM};
    for (int i = 0; i < 9; i++) begin
      case (i)
        0, 1, 2: set_in(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0);
        3:       set_in(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 1);
        4:       set_in(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        5:       set_in(0, 0, 0, 5'd0, 5'd0, 5'd0, 1, 1, 0);
        6:       set_in(1, 1, 1, 5'd7, 5'd2, 5'd7, 0, 1, 1);
        7:       set_in(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        default: set_in(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 1);
      endcase
      @(negedge clock);
      checks++;
      if (ctl !== exp[i]) begin
        errors++; $display("FAIL mem_wait[%0d]: got %b want %b", i, ctl, exp[i]);
      end
      next_cycle();
      if (i == 4) begin
        checks++;
        if (stall_cycles !== 3'd3) begin
          errors++; $display("FAIL mem_wait_stall3: got %0d want 3", stall_cycles);
        end
      end
    end
    checks++;
    if (stall_cycles !== 3'd5 || flush_events !== 3'd0) begin
      errors++; $display("FAIL mem_wait_cnt: got %0d/%0d want 5/0", stall_cycles, flush_events);
    end
  endtask

  task automatic test_watchdog();
    logic [7:0] exp [8];
    restart();
    exp = '{C_FRZ, C_FRZ, C_FRZ, C_ERR, C_ERR, C_ERR, C_ERR, C_ERR};
    for (int i = 0; i < 8; i++) begin
      if (i < 4) set_in(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0);
      else       set_in(0, 0, 0, 5'd0, 5'd0, 5'd0, 1, 0, 1);
      @(negedge clock);
      checks++;
      if (ctl !== exp[i]) begin
        errors++; $display("FAIL watchdog[%0d]: got %b want %b", i, ctl, exp[i]);
      end
      next_cycle();
      if (i == 5) begin
        checks++;
        if (stall_cycles !== 3'd6) begin
          errors++; $display("FAIL watchdog_stall6: got %0d want 6", stall_cycles);
        end
      end
    end
    checks++;
    if (stall_cycles !== 3'd7 || flush_events !== 3'd0) begin
      errors++; $display("FAIL stall_saturate: got %0d/%0d want 7/0", stall_cycles, flush_events);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (ctl !== C_BOOT || stall_cycles !== 3'd0) begin
      errors++; $display("FAIL error_reset: got %b/%0d want %b/0", ctl, stall_cycles, C_BOOT);
    end
    @(negedge clock);
    reset = 1'b1;
    set_in(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    next_cycle();
    checks++;
    if (ctl !== C_NORM) begin
      errors++; $display("FAIL error_recover: got %b want %b", ctl, C_NORM);
    end
  endtask

  task automatic test_back_to_back();
    restart();
    for (int i = 0; i < 9; i++) begin
      set_in(0, 0, 0, 5'd0, 5'd0, 5'd0, 1, 0, 0);
      @(negedge clock);
      checks++;
      if (ctl !== C_BR) begin
        errors++; $display("FAIL b2b_branch[%0d]: got %b want %b", i, ctl, C_BR);
      end
      next_cycle();
    end
    checks++;
    if (flush_events !== 3'd7) begin
      errors++; $display("FAIL flush_saturate: got %0d want 7", flush_events);
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_watchdog();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
